dmem_access_ctrl: RTL and testbench

Sequencer and arbiter in front of the word-wide data RAM. The RAM is synchronous, with 1-cycle read latency and no byte enables. The block serves two requesters: the CPU load/store port and the UART program loader. It performs byte/halfword extraction with sign extension on loads and read-modify-write for sub-word stores. Completion is signalled to each requester with a one-cycle ready pulse.

---
 rtl/dmem_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-RAM sequencer/arbiter: loader-priority grant, sub-word load extraction and
// read-modify-write stores. Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned CPU accesses.
module dmem_access_ctrl #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [1:0]        cpu_len,
   input  logic              cpu_sign,
   output logic              cpu_ready,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_err,
   input  logic              ldr_req,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [31:0]       ldr_wdata,
   output logic              ldr_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RD_WAIT = 3'd2,
      MERGE   = 3'd3,
      WR      = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      state_r, state_nxt_s;
   logic        grant_ldr_s, grant_cpu_s, no_ram_s, trap_s, trap_chk_s, owner_nxt_s;
   logic        owner_cpu_r, we_r, sign_r;
   logic [1:0]  len_r, off_r;
   logic [15:0] sdata_r;
   logic [31:0] word_r;
   logic        unused_s;

   // Address bits above the RAM window alias away by truncation.
   assign unused_s = ^{cpu_addr[30:ADDR_W+2]};

   function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] len,
                                                input logic [1:0] off, input logic sign);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (len)
         2'd0:    extract_lane = {{24{sign & b[7]}}, b};
         2'd1:    extract_lane = {{16{sign & h[15]}}, h};
         default: extract_lane = word;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] data,
                                              input logic [1:0] len, input logic [1:0] off);
      logic [31:0] m;
      m = word;
      case (len)
         2'd0:    m[{off, 3'b000} +: 8] = data[7:0];
         2'd1:    m[{off[1], 4'b0000} +: 16] = data;
         default: m = word;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] len, input logic [1:0] off);
      case (len)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = off[0];
         default: misaligned = (off != 2'b00);
      endcase
   endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
   logic cpu_err_r;
   assign trap_chk_s = misaligned(cpu_len, cpu_addr[1:0]);
   assign cpu_err    = cpu_err_r;

   // Error flag accompanies the ready pulse of a trapped access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cpu_err_r <= 1'b0;
      else     cpu_err_r <= trap_s;
   end
`else
   assign trap_chk_s = 1'b0;
   assign cpu_err    = 1'b0;
`endif

   assign ram_din     = word_r;
   assign no_ram_s    = cpu_addr[31] | trap_chk_s;
   assign owner_nxt_s = (state_r == IDLE) ? grant_cpu_s : owner_cpu_r;

   // Next-state logic and grant decode.
   always_comb begin
      state_nxt_s = state_r;
      grant_ldr_s = 1'b0;
      grant_cpu_s = 1'b0;
      trap_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (ldr_req) begin
               grant_ldr_s = 1'b1;
               state_nxt_s = WR;
            end else if (cpu_req) begin
               grant_cpu_s = 1'b1;
               trap_s      = ~cpu_addr[31] & trap_chk_s;
               if (no_ram_s)                  state_nxt_s = DONE;
               else if (cpu_we && cpu_len[1]) state_nxt_s = WR;
               else                           state_nxt_s = RD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RD:      state_nxt_s = RD_WAIT;
         RD_WAIT: state_nxt_s = we_r ? MERGE : DONE;
         MERGE:   state_nxt_s = WR;
         WR:      state_nxt_s = DONE;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

   // Registered outputs, latched request fields and the merge buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_we      <= 1'b0;
         busy        <= 1'b0;
         cpu_ready   <= 1'b0;
         ldr_ready   <= 1'b0;
         cpu_rdata   <= 32'd0;
         ram_addr    <= '0;
         word_r      <= 32'd0;
         sdata_r     <= 16'd0;
         owner_cpu_r <= 1'b0;
         we_r        <= 1'b0;
         sign_r      <= 1'b0;
         len_r       <= 2'd0;
         off_r       <= 2'd0;
      end else begin
         ram_we    <= (state_nxt_s == WR);
         busy      <= (state_nxt_s != IDLE);
         cpu_ready <= (state_nxt_s == DONE) &  owner_nxt_s;
         ldr_ready <= (state_nxt_s == DONE) & ~owner_nxt_s;
         if (grant_ldr_s) begin
            owner_cpu_r <= 1'b0;
            ram_addr    <= ldr_addr;
            word_r      <= ldr_wdata;
         end else if (grant_cpu_s) begin
            owner_cpu_r <= 1'b1;
            we_r        <= cpu_we;
            sign_r      <= cpu_sign;
            len_r       <= cpu_len;
            off_r       <= cpu_addr[1:0];
            sdata_r     <= cpu_wdata[15:0];
            word_r      <= cpu_wdata;
            if (no_ram_s) cpu_rdata <= 32'd0;
            else          ram_addr  <= cpu_addr[ADDR_W+1:2];
         end else if (state_r == RD_WAIT) begin
            if (we_r) word_r    <= ram_dout;
            else      cpu_rdata <= extract_lane(ram_dout, len_r, off_r, sign_r);
         end else if (state_r == MERGE) begin
            word_r <= merge_lane(word_r, sdata_r, len_r, off_r);
         end
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized accesses
// checked against an arithmetic reference model of memory contents and latencies.
module tb_dmem_access_ctrl;
   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_we, cpu_sign, cpu_ready, cpu_err;
   logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
   logic [1:0]        cpu_len;
   logic              ldr_req, ldr_ready;
   logic [ADDR_W-1:0] ldr_addr, ram_addr;
   logic [31:0]       ldr_wdata, ram_din, ram_dout;
   logic              ram_we, busy;

   logic [31:0] mem [0:(1<<ADDR_W)-1];
   logic [31:0] ref_mem [0:15];
   int          tests = 0;
   int          fails = 0;

   dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_len(cpu_len), .cpu_sign(cpu_sign), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .cpu_err(cpu_err), .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ready(ldr_ready), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_dout(ram_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                              input int len, input bit sign);
      longint w, v;
      int     sh;
      w = longint'(word);
      if (len == 0) begin
         sh = 8 * int'(addr % 4);
         v  = (w >> sh) % 256;
         if (sign && v >= 128) v = v - 256;
      end else if (len == 1) begin
         sh = 16 * int'((addr / 2) % 2);
         v  = (w >> sh) % 65536;
         if (sign && v >= 32768) v = v - 65536;
      end else begin
         v = w;
      end
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] addr,
                                               input int len, input logic [31:0] data);
      longint w, d;
      int     sh;
      w = longint'(word);
      d = longint'(data);
      if (len == 0) begin
         sh = 8 * int'(addr % 4);
         w  = w - (((w >> sh) % 256) << sh) + ((d % 256) << sh);
      end else if (len == 1) begin
         sh = 16 * int'((addr / 2) % 2);
         w  = w - (((w >> sh) % 65536) << sh) + ((d % 65536) << sh);
      end else begin
         w = d;
      end
      return w[31:0];
   endfunction

   function automatic bit model_mis(input logic [31:0] addr, input int len);
`ifdef DMEM_MISALIGN_TRAP_EN
      return (len == 1 && addr % 2 == 1) || (len >= 2 && addr % 4 != 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic cpu_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] len, input bit sign,
                         output logic [31:0] rd, output logic er, output int lat, output int wes);
      bit seen;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      cpu_len = len; cpu_sign = sign;
      lat = 0; wes = 0; seen = 1'b0; rd = 32'hxxxx_xxxx; er = 1'bx;
      while (!seen && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (ram_we) wes++;
         if (cpu_ready) begin
            seen = 1'b1; rd = cpu_rdata; er = cpu_err;
         end
      end
      if (!seen) lat = 99;
      cpu_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic ldr_op(input logic [ADDR_W-1:0] a, input logic [31:0] d, output int lat);
      bit seen;
      ldr_req = 1'b1; ldr_addr = a; ldr_wdata = d;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (ldr_ready) seen = 1'b1;
      end
      if (!seen) lat = 99;
      ldr_req = 1'b0;
      @(posedge clk); #1;
   endtask

   logic [31:0] rd, last_rd, addr, wd, exp_rd;
   logic        er;
   int          lat, wes, ll, cl, n, len, wa, exp_lat, exp_wes;
   bit          we, sign, mmio, mis;

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      cpu_len = 2'd0; cpu_sign = 1'b0; ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", {27'd0, ram_we, cpu_ready, ldr_ready, busy, cpu_err}, 32'd0);
      check("reset_ram_addr", {18'd0, ram_addr}, 32'd0);
      check("reset_cpu_rdata", cpu_rdata, 32'd0);
      check("reset_ram_din", ram_din, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      last_rd = 32'd0;

      // Fill the working window through the loader.
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         ldr_op(ADDR_W'(i), ref_mem[i], lat);
         check("fill_ldr_lat", lat, 32'd2);
      end

      ldr_op(14'd5, 32'hDEADBEEF, lat);
      ref_mem[5] = 32'hDEADBEEF;
      check("ldr_lat", lat, 32'd2);
      check("ldr_mem5", mem[5], 32'hDEADBEEF);
      cpu_op(1'b0, 32'h14, 32'd0, 2'd2, 1'b0, rd, er, lat, wes);
      check("ld_word", rd, 32'hDEADBEEF);
      check("ld_word_lat", lat, 32'd3);

      cpu_op(1'b1, 32'h16, 32'h0000_0055, 2'd0, 1'b0, rd, er, lat, wes);
      ref_mem[5] = 32'hDE55BEEF;
      check("sb_mem", mem[5], 32'hDE55BEEF);
      check("sb_lat", lat, 32'd5);
      check("sb_we_cycles", wes, 32'd1);
      check("sb_rdata_held", rd, 32'hDEADBEEF);

      cpu_op(1'b0, 32'h14, 32'd0, 2'd1, 1'b1, rd, er, lat, wes);
      check("lh_sext", rd, 32'hFFFFBEEF);
      cpu_op(1'b0, 32'h14, 32'd0, 2'd1, 1'b0, rd, er, lat, wes);
      check("lh_zext", rd, 32'h0000BEEF);
      cpu_op(1'b0, 32'h17, 32'd0, 2'd0, 1'b1, rd, er, lat, wes);
      check("lb_sext", rd, 32'hFFFFFFDE);
      check("lb_lat", lat, 32'd3);
      check("rdata_hold_idle", cpu_rdata, 32'hFFFFFFDE);

      cpu_op(1'b0, 32'h8000_0014, 32'd0, 2'd2, 1'b0, rd, er, lat, wes);
      check("mmio_rdata", rd, 32'd0);
      check("mmio_lat", lat, 32'd1);
      check("mmio_no_ram", wes, 32'd0);

      cpu_op(1'b0, 32'h15, 32'd0, 2'd2, 1'b0, rd, er, lat, wes);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("mis_err", {31'd0, er}, 32'd1);
      check("mis_lat", lat, 32'd1);
      check("mis_rdata", rd, 32'd0);
      last_rd = 32'd0;
`else
      check("mis_err", {31'd0, er}, 32'd0);
      check("mis_lat", lat, 32'd3);
      check("mis_rdata", rd, 32'hDE55BEEF);
      last_rd = 32'hDE55BEEF;
`endif

      // Simultaneous requests: loader first, CPU in the following IDLE.
      wd = $urandom;
      ldr_req = 1'b1; ldr_addr = 14'd7; ldr_wdata = wd;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1C; cpu_len = 2'd2; cpu_sign = 1'b0;
      n = 0; ll = 0; cl = 0; wes = 0;
      while (cl == 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (ram_we) wes++;
         if (ldr_ready) begin ll = n; ldr_req = 1'b0; end
         if (cpu_ready) begin cl = n; rd = cpu_rdata; end
      end
      cpu_req = 1'b0;
      @(posedge clk); #1;
      ref_mem[7] = wd;
      last_rd = wd;
      check("arb_ldr_lat", ll, 32'd2);
      check("arb_cpu_lat", cl, 32'd6);
      check("arb_cpu_rdata", rd, wd);
      check("arb_we_cycles", wes, 32'd1);

      // Reset during MERGE of a byte store to word 6.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h19; cpu_wdata = 32'hA5; cpu_len = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("merge_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_ctrl", {27'd0, ram_we, cpu_ready, ldr_ready, busy, cpu_err}, 32'd0);
      check("abort_ram_addr", {18'd0, ram_addr}, 32'd0);
      check("abort_rdata", cpu_rdata, 32'd0);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      wes = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ram_we || cpu_ready) wes++;
      end
      check("abort_quiet", wes, 32'd0);
      check("abort_mem6", mem[6], ref_mem[6]);
      last_rd = 32'd0;

      // Randomized traffic against the reference model.
      for (int t = 0; t < 80; t++) begin
         if ($urandom_range(0, 5) == 0) begin
            wa = $urandom_range(0, 15);
            wd = $urandom;
            ldr_op(ADDR_W'(wa), wd, lat);
            ref_mem[wa] = wd;
            check("rnd_ldr_lat", lat, 32'd2);
         end else begin
            we   = 1'($urandom_range(0, 1));
            sign = 1'($urandom_range(0, 1));
            len  = $urandom_range(0, 3);
            mmio = ($urandom_range(0, 7) == 0);
            addr = {1'b0, 15'($urandom_range(0, 32767)), 10'd0, 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3))};
            if (mmio) addr[31] = 1'b1;
            wd   = $urandom;
            wa   = int'((addr / 4) % (1 << ADDR_W));
            mis  = !mmio && model_mis(addr, len);
            if (mmio || mis) begin
               exp_rd = 32'd0; exp_lat = 1; exp_wes = 0;
            end else if (we) begin
               exp_rd  = last_rd;
               exp_lat = (len >= 2) ? 2 : 5;
               exp_wes = 1;
               ref_mem[wa] = model_store(ref_mem[wa], addr, len, wd);
            end else begin
               exp_rd = model_load(ref_mem[wa], addr, len, sign);
               exp_lat = 3; exp_wes = 0;
            end
            cpu_op(we, addr, wd, 2'(len), sign, rd, er, lat, wes);
            last_rd = exp_rd;
            check("rnd_rdata", rd, exp_rd);
            check("rnd_lat", lat, 32'(exp_lat));
            check("rnd_we_cycles", wes, 32'(exp_wes));
            check("rnd_err", {31'd0, er}, {31'd0, mis});
            if (!mmio && !mis) check("rnd_mem", mem[wa], ref_mem[wa]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
